// File: rtl/game_round.sv
// game_round: whack-a-LED play engine for the in-game state.
// One target LED is lit during a round. Flipping that switch scores and moves the
// target. Flipping any other switch costs points. A 1 Hz enable runs the countdown,
// and done pulses once when the countdown reaches zero.
module game_round #(
  parameter int          ROUND_SECONDS = 30,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          HIT_POINTS    = 1,
  parameter int          MISS_PENALTY  = 1
) (
  input  logic               clk,
  input  logic               resetGame,
  input  logic               initialize,
  input  logic               tick_1hz,
  input  logic [15:0]        switches,
  output logic [15:0]        leds,
  output logic signed [10:0] score,
  output logic [5:0]         countdown_game,
  output logic               active,
  output logic               done
);

  localparam logic [5:0]  ROUND_INIT = 6'(ROUND_SECONDS);
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam int          SCORE_MAX  = 1023;
  localparam int          SCORE_MIN  = -1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [15:0]        lfsr;
  logic [15:0]        sw_prev;
  logic [3:0]         target;

  logic [15:0]        lfsr_next;
  logic [3:0]         draw_idx;
  logic [15:0]        tog;
  logic               hit;
  logic               miss;
  logic signed [10:0] score_next;
  int                 score_acc;

  function automatic logic [15:0] onehot(input logic [3:0] idx);
    onehot = 16'h0001 << idx;
  endfunction

  // Galois LFSR step, and the next target, which must never repeat the current one
  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    draw_idx  = lfsr[3:0];
    if (lfsr[3:0] == target) begin
      draw_idx = lfsr[3:0] + 4'd1;
    end
  end

  // Classify the switch change: only an exact flip of the lit switch is a hit
  always_comb begin
    tog  = switches ^ sw_prev;
    hit  = (tog == onehot(target));
    miss = (tog != 16'h0000) && !hit;
  end

  // Score after this cycle's hit or miss, clamped to the signed 11-bit range
  always_comb begin
    score_acc = int'(score);
    if (hit) begin
      score_acc = score_acc + HIT_POINTS;
    end else if (miss) begin
      score_acc = score_acc - MISS_PENALTY;
    end
    if (score_acc > SCORE_MAX) begin
      score_acc = SCORE_MAX;
    end else if (score_acc < SCORE_MIN) begin
      score_acc = SCORE_MIN;
    end
    score_next = 11'(score_acc);
  end

  // Round FSM with registered outputs; initialize restarts from any state
  always_ff @(posedge clk) begin
    if (resetGame) begin
      state          <= ST_IDLE;
      leds           <= 16'h0000;
      score          <= 11'sd0;
      countdown_game <= ROUND_INIT;
      active         <= 1'b0;
      done           <= 1'b0;
      lfsr           <= LFSR_SEED;
      sw_prev        <= switches;
      target         <= 4'd0;
    end else begin
      lfsr    <= lfsr_next;
      sw_prev <= switches;
      done    <= 1'b0;
      if (initialize) begin
        state          <= ST_PLAY;
        score          <= 11'sd0;
        countdown_game <= ROUND_INIT;
        target         <= draw_idx;
        leds           <= onehot(draw_idx);
        active         <= 1'b1;
      end else begin
        case (state)
          ST_PLAY: begin
            score <= score_next;
            if (hit) begin
              target <= draw_idx;
              leds   <= onehot(draw_idx);
            end
            if (tick_1hz) begin
              if (countdown_game == 6'd1) begin
                state          <= ST_DONE;
                countdown_game <= 6'd0;
                leds           <= 16'h0000;
                active         <= 1'b0;
                done           <= 1'b1;
              end else begin
                countdown_game <= countdown_game - 6'd1;
              end
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_round.sv
// tb_game_round: randomized and directed stimulus for game_round. A behavioural
// model predicts every cycle's outputs into a queue, and a monitor checks them.
module tb_game_round;

  localparam int          ROUND_SECONDS = 30;
  localparam logic [15:0] SEED          = 16'hACE1;
  localparam int          HP            = 1;
  localparam int          MP            = 1;

  logic               clk = 1'b0;
  logic               resetGame;
  logic               initialize;
  logic               tick_1hz;
  logic [15:0]        switches;
  logic [15:0]        leds;
  logic signed [10:0] score;
  logic [5:0]         countdown_game;
  logic               active;
  logic               done;

  game_round #(
    .ROUND_SECONDS(ROUND_SECONDS),
    .LFSR_SEED(SEED),
    .HIT_POINTS(HP),
    .MISS_PENALTY(MP)
  ) dut (
    .clk(clk),
    .resetGame(resetGame),
    .initialize(initialize),
    .tick_1hz(tick_1hz),
    .switches(switches),
    .leds(leds),
    .score(score),
    .countdown_game(countdown_game),
    .active(active),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_PLAY, M_OVER} phase_t;

  typedef struct {
    logic [15:0] leds;
    int          score;
    int          secs;
    bit          active;
    bit          done;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;

  phase_t      m_phase;
  int          m_score;
  int          m_secs;
  logic [3:0]  m_target;
  logic [15:0] m_lfsr;
  logic [15:0] m_swp;
  bit          m_done;
  logic [15:0] sw_cur = 16'h0000;

  // Reference model: one clock of the game rules
  task automatic modelStep(input bit rst, input bit init, input bit tick, input logic [15:0] sw);
    logic [3:0]  draw;
    logic [15:0] tog;
    if (rst) begin
      m_phase  = M_IDLE;
      m_score  = 0;
      m_secs   = ROUND_SECONDS;
      m_target = 4'd0;
      m_lfsr   = SEED;
      m_swp    = sw;
      m_done   = 1'b0;
    end else begin
      draw = m_lfsr[3:0];
      if (draw == m_target) draw = draw + 4'd1;
      tog    = sw ^ m_swp;
      m_done = 1'b0;
      if (init) begin
        m_phase  = M_PLAY;
        m_score  = 0;
        m_secs   = ROUND_SECONDS;
        m_target = draw;
      end else if (m_phase == M_PLAY) begin
        if (tog != 16'h0000) begin
          if (tog == (16'h0001 << m_target)) begin
            m_score  = (m_score + HP > 1023) ? 1023 : m_score + HP;
            m_target = draw;
          end else begin
            m_score = (m_score - MP < -1024) ? -1024 : m_score - MP;
          end
        end
        if (tick) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin
            m_phase = M_OVER;
            m_done  = 1'b1;
          end
        end
      end
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      m_swp  = sw;
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after that edge
  task automatic applyStimulus(input bit rst, input bit init, input bit tick, input logic [15:0] sw);
    exp_t e;
    @(negedge clk);
    resetGame  = rst;
    initialize = init;
    tick_1hz   = tick;
    switches   = sw;
    sw_cur     = sw;
    modelStep(rst, init, tick, sw);
    e.leds   = (m_phase == M_PLAY) ? (16'h0001 << m_target) : 16'h0000;
    e.score  = m_score;
    e.secs   = m_secs;
    e.active = (m_phase == M_PLAY);
    e.done   = m_done;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic signed [10:0] want_score;
    want_score = 11'(e.score);
    total++;
    if (leds !== e.leds) begin
      bad++;
      $display("[TB] FAIL leds got=%h want=%h t=%0t", leds, e.leds, $time);
    end
    total++;
    if (score !== want_score) begin
      bad++;
      $display("[TB] FAIL score got=%0d want=%0d t=%0t", score, want_score, $time);
    end
    total++;
    if (countdown_game !== 6'(e.secs)) begin
      bad++;
      $display("[TB] FAIL countdown got=%0d want=%0d t=%0t", countdown_game, e.secs, $time);
    end
    total++;
    if (active !== e.active) begin
      bad++;
      $display("[TB] FAIL active got=%b want=%b t=%0t", active, e.active, $time);
    end
    total++;
    if (done !== e.done) begin
      bad++;
      $display("[TB] FAIL done got=%b want=%b t=%0t", done, e.done, $time);
    end
  endtask

  function automatic logic [15:0] otherBit();
    logic [3:0] b;
    b = m_target + 4'(1 + $urandom_range(0, 14));
    return 16'h0001 << b;
  endfunction

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, sw_cur);
  endtask

  task automatic doHit(input bit tick);
    applyStimulus(1'b0, 1'b0, tick, sw_cur ^ (16'h0001 << m_target));
  endtask

  task automatic doMiss();
    applyStimulus(1'b0, 1'b0, 1'b0, sw_cur ^ otherBit());
  endtask

  task automatic doCombo();
    applyStimulus(1'b0, 1'b0, 1'b0, sw_cur ^ (16'h0001 << m_target) ^ otherBit());
  endtask

  // Monitor: after each edge compare the DUT against the oldest prediction
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    int r;
    logic [15:0] sw;
    resetGame  = 1'b1;
    initialize = 1'b0;
    tick_1hz   = 1'b0;
    switches   = 16'h0000;

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h00F0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 16'($urandom));

    applyStimulus(1'b0, 1'b1, 1'b0, sw_cur);
    idle(2);
    doHit(1'b0);
    idle(1);
    doMiss();
    doCombo();
    idle(2);

    for (int i = 0; i < 3; i++) doHit(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, sw_cur);
    idle(2);

    for (int i = 0; i < 5; i++) doHit(1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, sw_cur);
    idle(3);

    applyStimulus(1'b0, 1'b1, 1'b0, sw_cur);
    for (int i = 0; i < ROUND_SECONDS - 1; i++) begin
      if (i % 3 == 0) doHit(1'b1);
      else if (i % 3 == 1) doMiss();
      else applyStimulus(1'b0, 1'b0, 1'b1, sw_cur);
    end
    doHit(1'b1);
    for (int i = 0; i < 4; i++) doHit(1'b1);
    doMiss();
    idle(2);

    applyStimulus(1'b0, 1'b1, 1'b0, sw_cur);
    for (int i = 0; i < 1030; i++) doHit(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, sw_cur);
    for (int i = 0; i < 1030; i++) doMiss();

    applyStimulus(1'b0, 1'b1, 1'b0, sw_cur);
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 999);
      sw = sw_cur;
      case ($urandom_range(0, 7))
        0, 1, 2: sw = sw_cur ^ (16'h0001 << m_target);
        3:       sw = sw_cur ^ otherBit();
        4:       sw = sw_cur ^ (16'h0001 << m_target) ^ otherBit();
        5:       sw = 16'($urandom);
        default: sw = sw_cur;
      endcase
      applyStimulus(r < 3, (r >= 3) && (r < 9), ($urandom_range(0, 7) == 0), sw);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
